// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: debounced set/clear request lines to clean, non-overlapping
// S/R pulses for a downstream SR flip-flop, with an expected-Q model.
//
// Ports:
//   clk      - single clock, all state on rising edge
//   rst_n    - synchronous active-low reset
//   set_req  - raw asynchronous set request level
//   clr_req  - raw asynchronous clear request level
//   S, R     - registered drives to the flip-flop, never high together
//   busy     - high while a pulse or its trailing gap is in progress
//   q_model  - expected flip-flop Q after the last completed pulse
//   conflict - one-cycle flag for coincident set/clear edges
module sr_drive_ctrl #(
    parameter int DB_CYC    = 4,
    parameter int PULSE_CYC = 3,
    parameter int GAP_CYC   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    output logic S,
    output logic R,
    output logic busy,
    output logic q_model,
    output logic conflict
);

    localparam int DBW  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
    localparam logic [TW-1:0]  P_LAST  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0]  G_LAST  = TW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRV_S,
        DRV_R,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        C_NONE,
        C_SET,
        C_CLR
    } cmd_t;

    // Bit 0 carries the set line, bit 1 the clear line.
    logic [1:0]     s1;
    logic [1:0]     s2;
    logic [1:0]     db;
    logic [1:0]     db_d;
    logic [DBW-1:0] db_cnt [2];

    state_t         state;
    cmd_t           slot;
    logic [TW-1:0]  tcnt;

    logic           set_edge;
    logic           clr_edge;
    logic           new_req;
    cmd_t           new_cmd;
    cmd_t           idle_cmd;

    // Synchronizer and debouncer. db only moves after s2 has disagreed
    // with it for DB_CYC consecutive edges; any agreement restarts the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            db        <= '0;
            db_d      <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            s1   <= {clr_req, set_req};
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign set_edge = db[0] & ~db_d[0];
    assign clr_edge = db[1] & ~db_d[1];

    // A coincident pair is a request that cancels: new_req with C_NONE
    // empties the slot instead of leaving an older entry behind.
    always_comb begin
        new_req = set_edge | clr_edge;
        new_cmd = C_NONE;
        unique case (1'b1)
            set_edge & ~clr_edge: new_cmd = C_SET;
            clr_edge & ~set_edge: new_cmd = C_CLR;
            default:              new_cmd = C_NONE;
        endcase
    end

    assign idle_cmd = new_req ? new_cmd : slot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot     <= C_NONE;
            tcnt     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            q_model  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= set_edge & clr_edge;
            if (new_req) begin
                slot <= new_cmd;
            end
            unique case (state)
                IDLE: begin
                    slot <= C_NONE;
                    tcnt <= '0;
                    if (idle_cmd == C_SET) begin
                        state <= DRV_S;
                        S     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (idle_cmd == C_CLR) begin
                        state <= DRV_R;
                        R     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DRV_S, DRV_R: begin
                    if (tcnt == P_LAST) begin
                        state   <= GAP;
                        S       <= 1'b0;
                        R       <= 1'b0;
                        q_model <= (state == DRV_S);
                        tcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    if (tcnt == G_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed scenarios plus random request traffic for
// sr_drive_ctrl, checked each cycle against a timer-based reference model.
module tb_sr_drive_ctrl;

    localparam int DB_CYC    = 4;
    localparam int PULSE_CYC = 3;
    localparam int GAP_CYC   = 2;
    localparam int LO        = DB_CYC + 2;
    localparam int HI        = LO + PULSE_CYC - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic S;
    logic R;
    logic busy;
    logic q_model;
    logic conflict;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-line sample history and run length, and the
    // drive sequencer as "pulse cycles left" / "gap cycles left" timers.
    int m_s1 [2];
    int m_s2 [2];
    int m_db [2];
    int m_dbp[2];
    int m_run[2];
    int m_pend;
    int m_kind;
    int m_pl;
    int m_gl;
    int m_q;
    int m_conf;

    sr_drive_ctrl #(
        .DB_CYC   (DB_CYC),
        .PULSE_CYC(PULSE_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .clr_req (clr_req),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .q_model (q_model),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk5(input string tag, input logic [4:0] obs,
                        input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_s1[j]  = 0;
            m_s2[j]  = 0;
            m_db[j]  = 0;
            m_dbp[j] = 0;
            m_run[j] = 0;
        end
        m_pend = 0;
        m_kind = 0;
        m_pl   = 0;
        m_gl   = 0;
        m_q    = 0;
        m_conf = 0;
    endtask

    // Commands: 0 none, 1 set, 2 clear.
    task automatic model_edge(input bit sr, input bit cr, input bit rn);
        int se;
        int ce;
        int a;
        int c;
        int raw[2];
        if (!rn) begin
            model_reset();
            return;
        end
        se = (m_db[0] == 1 && m_dbp[0] == 0) ? 1 : 0;
        ce = (m_db[1] == 1 && m_dbp[1] == 0) ? 1 : 0;
        m_conf = se & ce;
        a = -1;
        if (se == 1 && ce == 1) a = 0;
        else if (se == 1) a = 1;
        else if (ce == 1) a = 2;
        if (m_pl == 0 && m_gl == 0) begin
            c = (a >= 0) ? a : m_pend;
            m_pend = 0;
            if (c != 0) begin
                m_kind = c;
                m_pl   = PULSE_CYC;
            end
        end else begin
            if (a >= 0) m_pend = a;
            if (m_pl > 0) begin
                m_pl--;
                if (m_pl == 0) begin
                    m_q  = (m_kind == 1) ? 1 : 0;
                    m_gl = GAP_CYC;
                end
            end else begin
                m_gl--;
            end
        end
        raw[0] = sr;
        raw[1] = cr;
        for (int j = 0; j < 2; j++) begin
            m_dbp[j] = m_db[j];
            if (m_s2[j] != m_db[j]) begin
                m_run[j]++;
                if (m_run[j] == DB_CYC) begin
                    m_db[j]  = m_s2[j];
                    m_run[j] = 0;
                end
            end else begin
                m_run[j] = 0;
            end
            m_s2[j] = m_s1[j];
            m_s1[j] = raw[j];
        end
    endtask

    task automatic step(input bit sr, input bit cr, input bit rn);
        logic [4:0] e;
        set_req = sr;
        clr_req = cr;
        rst_n   = rn;
        @(posedge clk);
        model_edge(sr, cr, rn);
        @(negedge clk);
        e = {(m_pl > 0 && m_kind == 1), (m_pl > 0 && m_kind == 2),
             (m_pl > 0 || m_gl > 0), (m_q == 1), (m_conf == 1)};
        chk5("model", {S, R, busy, q_model, conflict}, e);
        chk1("s_and_r", S & R, 1'b0);
    endtask

    initial begin
        int s_rises;
        int r_rises;
        logic ps;
        logic pr;
        bit rs;
        bit rc;
        bit rn;
        model_reset();
        set_req = 1'b0;
        clr_req = 1'b0;
        rst_n   = 1'b0;

        // Reset held with set_req high, then a single command afterwards.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk5("rst_zero", {S, R, busy, q_model, conflict}, 5'b0);
        end
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 1);
            chk1("rst_rel_s", S, (i >= LO && i <= HI));
            if (i == HI + 1) chk1("rst_rel_q", q_model, 1'b1);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        // Set then clear from idle.
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 1);
            chk1("set_s", S, (i >= LO && i <= HI));
            chk1("set_busy", busy, (i >= LO && i <= HI + GAP_CYC));
        end
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 1);
            chk1("clr_r", R, (i >= LO && i <= HI));
            chk1("clr_s", S, 1'b0);
            chk1("clr_q", q_model, (i <= HI));
        end
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 30; i++) begin
            step((i < 20) && (((i / 2) % 2) == 0), 0, 1);
            chk1("bounce_s", S, 1'b0);
            chk1("bounce_busy", busy, 1'b0);
        end

        // Queued set behind an R pulse, then a clear overwritten by a set
        // while the S pulse runs: only one more S, no R.
        s_rises = 0;
        r_rises = 0;
        ps = S;
        pr = R;
        for (int i = 0; i <= 40; i++) begin
            step((i >= 1 && i <= 4) || (i >= 9 && i <= 25),
                 (i <= 3) || (i >= 8 && i <= 25), 1);
            if (i >= 15 && S && !ps) s_rises++;
            if (i >= 15 && R && !pr) r_rises++;
            ps = S;
            pr = R;
        end
        chki("queued_s_pulses", s_rises, 1);
        chki("queued_r_pulses", r_rises, 0);
        chk1("queued_q", q_model, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);

        // Coincident edges from idle.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1);
            chk1("conf_flag", conflict, (i == LO));
            chk5("conf_quiet", {S, R, busy}, 5'b0);
        end
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        // Reset in the second cycle of an R pulse while q_model is 1.
        for (int i = 0; i <= LO + 2; i++) begin
            step(0, 1, (i != LO + 2));
            if (i == LO + 1) chk5("mid_pre", {R, q_model}, 5'b00011);
            if (i == LO + 2) chk5("mid_rst", {R, q_model, busy}, 5'b0);
        end
        step(0, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1);

        // Random traffic with occasional resets.
        rs = 0;
        rc = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            if ($urandom_range(0, 5) == 0) rc = ~rc;
            rn = ($urandom_range(0, 99) != 0);
            step(rs, rc, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
